// File: rtl/max_test3_pkg.sv
// Shared types and default sizes for the max_test3 packet-maximum tracker.
// The optional beat-index output is enabled by defining MAX_TEST3_INDEX_EN.
package max_test3_pkg;

    localparam int DEF_STREAM_WIDTH = 32;
    localparam int DEF_CNT_WIDTH    = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/max_test3_if.sv
// AXI-Stream input plus per-packet result bundle for max_test3.
// Handshake: a beat transfers on a rising aclk edge where tvalid and tready are both 1.
interface max_test3_if
    import max_test3_pkg::*;
#(
    parameter int STREAM_WIDTH = DEF_STREAM_WIDTH,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input logic aclk
);

    logic                    tvalid;
    logic                    tready;
    logic [STREAM_WIDTH-1:0] tdata;
    logic                    tlast;
    logic [STREAM_WIDTH-1:0] max_out;
    logic                    max_valid;
    logic [CNT_WIDTH-1:0]    pkt_len;
`ifdef MAX_TEST3_INDEX_EN
    logic [CNT_WIDTH-1:0]    max_idx;
`endif

    modport master (
        input  aclk,
        output tvalid, tdata, tlast,
        input  tready, max_out, max_valid, pkt_len
`ifdef MAX_TEST3_INDEX_EN
        , input max_idx
`endif
    );

    modport slave (
        input  aclk,
        input  tvalid, tdata, tlast,
        output tready, max_out, max_valid, pkt_len
`ifdef MAX_TEST3_INDEX_EN
        , output max_idx
`endif
    );

endinterface

// File: rtl/max_test3_cmp.sv
// Unsigned strict-greater compare-and-select: ties keep the current value.
module max_test3_cmp #(
    parameter int W = 32
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] cand,
    output logic [W-1:0] sel_val,
    output logic         take
);

    assign take    = (cand > cur);
    assign sel_val = take ? cand : cur;

endmodule

// File: rtl/max_test3.sv
// Per-packet maximum and length tracker on an always-ready AXI-Stream slave.
// Define MAX_TEST3_INDEX_EN to add max_idx, the beat index of the first maximum.
module max_test3
    import max_test3_pkg::*;
#(
    parameter int STREAM_WIDTH = DEF_STREAM_WIDTH,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                    ACLK,
    input  logic                    ARESET_n,
    output logic                    TREADY,
    input  logic [STREAM_WIDTH-1:0] TDATA,
    input  logic                    TLAST,
    input  logic                    TVALID,
    output logic [STREAM_WIDTH-1:0] max_out,
    output logic                    max_valid,
    output logic [CNT_WIDTH-1:0]    pkt_len
`ifdef MAX_TEST3_INDEX_EN
    ,
    output logic [CNT_WIDTH-1:0]    max_idx
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_e                  state_q, state_d;
    logic                    tready_q;
    logic [STREAM_WIDTH-1:0] run_max_q, run_max_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d;
    logic [STREAM_WIDTH-1:0] max_out_q, max_out_d;
    logic                    max_valid_q, max_valid_d;
    logic [CNT_WIDTH-1:0]    pkt_len_q, pkt_len_d;
`ifdef MAX_TEST3_INDEX_EN
    logic [CNT_WIDTH-1:0]    run_idx_q, run_idx_d;
    logic [CNT_WIDTH-1:0]    max_idx_q, max_idx_d;
`endif

    logic                    accept;
    logic                    take;
    logic [STREAM_WIDTH-1:0] sel_val;
    logic [CNT_WIDTH-1:0]    cnt_inc;

    assign accept  = TVALID & tready_q;
    assign cnt_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;

    max_test3_cmp #(.W(STREAM_WIDTH)) u_cmp (
        .cur     (run_max_q),
        .cand    (TDATA),
        .sel_val (sel_val),
        .take    (take)
    );

    always_comb begin
        state_d     = state_q;
        run_max_d   = run_max_q;
        count_d     = count_q;
        max_out_d   = max_out_q;
        pkt_len_d   = pkt_len_q;
        max_valid_d = 1'b0;
`ifdef MAX_TEST3_INDEX_EN
        run_idx_d   = run_idx_q;
        max_idx_d   = max_idx_q;
`endif
        if (accept) begin
            if (state_q == ST_IDLE) begin
                if (TLAST) begin
                    max_out_d = TDATA;
                    pkt_len_d = CNT_ONE;
`ifdef MAX_TEST3_INDEX_EN
                    max_idx_d = '0;
`endif
                end else begin
                    run_max_d = TDATA;
                    count_d   = CNT_ONE;
                    state_d   = ST_ACCUM;
`ifdef MAX_TEST3_INDEX_EN
                    run_idx_d = '0;
`endif
                end
            end else begin
                // The beat's zero-based index equals the count before it.
                count_d = cnt_inc;
                if (take) begin
                    run_max_d = TDATA;
`ifdef MAX_TEST3_INDEX_EN
                    run_idx_d = count_q;
`endif
                end
                if (TLAST) begin
                    max_out_d = sel_val;
                    pkt_len_d = cnt_inc;
                    state_d   = ST_IDLE;
`ifdef MAX_TEST3_INDEX_EN
                    max_idx_d = take ? count_q : run_idx_q;
`endif
                end
            end
            max_valid_d = TLAST;
        end
    end

    always_ff @(posedge ACLK or negedge ARESET_n) begin
        if (!ARESET_n) begin
            state_q     <= ST_IDLE;
            tready_q    <= 1'b0;
            run_max_q   <= '0;
            count_q     <= '0;
            max_out_q   <= '0;
            max_valid_q <= 1'b0;
            pkt_len_q   <= '0;
`ifdef MAX_TEST3_INDEX_EN
            run_idx_q   <= '0;
            max_idx_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tready_q    <= 1'b1;
            run_max_q   <= run_max_d;
            count_q     <= count_d;
            max_out_q   <= max_out_d;
            max_valid_q <= max_valid_d;
            pkt_len_q   <= pkt_len_d;
`ifdef MAX_TEST3_INDEX_EN
            run_idx_q   <= run_idx_d;
            max_idx_q   <= max_idx_d;
`endif
        end
    end

    assign TREADY    = tready_q;
    assign max_out   = max_out_q;
    assign max_valid = max_valid_q;
    assign pkt_len   = pkt_len_q;
`ifdef MAX_TEST3_INDEX_EN
    assign max_idx   = max_idx_q;
`endif

endmodule

// File: tb/tb_max_test3.sv
// Directed self-checking bench for max_test3 (default 32-bit data, 16-bit counters).
`timescale 1ns/1ps
module tb_max_test3;
    import max_test3_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    max_test3_if #(.STREAM_WIDTH(32), .CNT_WIDTH(16)) bus (.aclk(clk));

    max_test3 dut (
        .ACLK      (clk),
        .ARESET_n  (rst_n),
        .TREADY    (bus.tready),
        .TDATA     (bus.tdata),
        .TLAST     (bus.tlast),
        .TVALID    (bus.tvalid),
        .max_out   (bus.max_out),
        .max_valid (bus.max_valid),
        .pkt_len   (bus.pkt_len)
`ifdef MAX_TEST3_INDEX_EN
        ,
        .max_idx   (bus.max_idx)
`endif
    );

    // Clock: posedges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    endtask

    // Drive one beat, consume exactly one edge, sample point is #1 after that edge.
    task automatic send_beat(input logic [31:0] data, input logic last);
        bus.tvalid = 1'b1;
        bus.tdata  = data;
        bus.tlast  = last;
        @(posedge clk);
        #1;
        bus.tvalid = 1'b0;
        bus.tlast  = 1'b0;
    endtask

    task automatic idle_cycle(input logic [31:0] junk);
        bus.tvalid = 1'b0;
        bus.tdata  = junk;
        bus.tlast  = 1'b1;
        @(posedge clk);
        #1;
        bus.tlast  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] exp_max,
                                input logic [31:0] exp_len, input logic [31:0] exp_idx);
        check_eq({tag, "_valid"}, 32'(bus.max_valid), 32'd1);
        check_eq({tag, "_max"}, bus.max_out, exp_max);
        check_eq({tag, "_len"}, 32'(bus.pkt_len), exp_len);
`ifdef MAX_TEST3_INDEX_EN
        check_eq({tag, "_idx"}, 32'(bus.max_idx), exp_idx);
`else
        if (exp_idx == 32'hFFFF_FFFF) $display("note: bad index argument in %s", tag);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_tready"}, 32'(bus.tready), 32'd0);
        check_eq({tag, "_max"}, bus.max_out, 32'd0);
        check_eq({tag, "_valid"}, 32'(bus.max_valid), 32'd0);
        check_eq({tag, "_len"}, 32'(bus.pkt_len), 32'd0);
`ifdef MAX_TEST3_INDEX_EN
        check_eq({tag, "_idx"}, 32'(bus.max_idx), 32'd0);
`endif
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        bus.tvalid = 1'b0;
        bus.tdata  = '0;
        bus.tlast  = 1'b0;

        // Reset held low ~20 ns, released between edges.
        rst_n = 1'b0;
        #22;
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        check_eq("tready_before_edge", 32'(bus.tready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("tready_after_edge", 32'(bus.tready), 32'd1);

        // Rising max ending on the last beat.
        send_beat(32'd5, 1'b0);
        send_beat(32'd900, 1'b0);
        send_beat(32'd3, 1'b0);
        check_eq("no_pulse_mid_pkt", 32'(bus.max_valid), 32'd0);
        send_beat(32'd65000, 1'b1);
        check_result("pkt1", 32'd65000, 32'd4, 32'd3);
        idle_cycle(32'd12345);
        check_eq("pulse_one_cycle", 32'(bus.max_valid), 32'd0);
        check_eq("hold_max", bus.max_out, 32'd65000);
        check_eq("hold_len", 32'(bus.pkt_len), 32'd4);

        // Single-beat packet straight from IDLE.
        send_beat(32'd42, 1'b1);
        check_result("single", 32'd42, 32'd1, 32'd0);
        idle_cycle(32'd0);

        // Equal values: first occurrence of the max wins.
        send_beat(32'd7, 1'b0);
        send_beat(32'd9, 1'b0);
        send_beat(32'd9, 1'b0);
        send_beat(32'd1, 1'b1);
        check_result("ties", 32'd9, 32'd4, 32'd1);
        idle_cycle(32'd0);

        // Gap mid-packet (ignored TDATA/TLAST), then back-to-back packet.
        send_beat(32'd10, 1'b0);
        idle_cycle(32'd999);
        check_eq("gap_no_pulse", 32'(bus.max_valid), 32'd0);
        send_beat(32'd20, 1'b1);
        check_result("gap", 32'd20, 32'd2, 32'd1);
        send_beat(32'd3, 1'b1);
        check_result("b2b", 32'd3, 32'd1, 32'd0);
        idle_cycle(32'd0);

        // Max first, later values all smaller: max_out must not follow the last beat.
        send_beat(32'hFFFF_FFFF, 1'b0);
        send_beat(32'd8, 1'b0);
        send_beat(32'd2, 1'b1);
        check_result("first_max", 32'hFFFF_FFFF, 32'd3, 32'd0);
        idle_cycle(32'd0);

        // Reset mid-packet discards the partial packet.
        send_beat(32'd100, 1'b0);
        send_beat(32'd200, 1'b0);
        rst_n = 1'b0;
        #2;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midreset_tready", 32'(bus.tready), 32'd1);
        send_beat(32'd50, 1'b1);
        check_result("after_reset", 32'd50, 32'd1, 32'd0);
        idle_cycle(32'd0);

        // Long packet: beat count saturates at 65535, max tracking continues.
        for (int i = 0; i < 65536; i++) begin
            send_beat((i == 1000 || i == 2000) ? 32'hFFFF_FFF0 : 32'(i), 1'b0);
        end
        send_beat(32'd7, 1'b1);
        check_result("saturate", 32'hFFFF_FFF0, 32'd65535, 32'd1000);
        idle_cycle(32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/max_test3.md
MAX_TEST3 -- requirements
Module: max_test3

Interface
REQ-001 The block SHALL have parameter STREAM_WIDTH, default 32: TDATA width in bits.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16: width of beat counter and length/index outputs.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, named ACLK and ARESET_n as the codebase does.
REQ-004 The port ACLK SHALL be: input, 1 bit, the single clock, all state on rising edge.
REQ-005 The port ARESET_n SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-006 The port TREADY SHALL be: output, 1 bit, AXI-Stream slave ready.
REQ-007 The port TDATA SHALL be: input, STREAM_WIDTH bits, stream payload, unsigned.
REQ-008 The port TLAST SHALL be: input, 1 bit, marks the final beat of a packet.
REQ-009 The port TVALID SHALL be: input, 1 bit, payload valid.
REQ-010 The port max_out SHALL be: output, STREAM_WIDTH bits, maximum of the last completed packet.
REQ-011 The port max_valid SHALL be: output, 1 bit, one-cycle pulse when max_out/pkt_len update.
REQ-012 The port pkt_len SHALL be: output, CNT_WIDTH bits, beat count of the last completed packet.
REQ-013 Positional port order SHALL be ACLK, ARESET_n, TREADY, TDATA, TLAST, TVALID, max_out, max_valid, pkt_len[, max_idx].

Function
REQ-014 A beat SHALL be accepted only on a rising edge with TVALID=1 and TREADY=1; TDATA/TLAST are ignored otherwise.
REQ-015 TREADY SHALL be registered: 0 in reset, 1 from the first rising edge after ARESET_n deasserts, and stay 1 (no backpressure).
REQ-016 The FSM SHALL have states IDLE (no beat of the current packet accepted) and ACCUM (at least one accepted).
REQ-017 In IDLE, an accepted non-last beat SHALL load run_max=TDATA, count=1, go to ACCUM.
REQ-018 In ACCUM, an accepted non-last beat SHALL set run_max=TDATA only if TDATA > run_max (unsigned, strict), count+1.
REQ-019 An accepted TLAST beat in either state SHALL register max_out = max(run_max, TDATA) (TDATA alone from IDLE) and pkt_len = count+1, pulse max_valid on the following cycle, and return to IDLE.
REQ-020 Result latency SHALL be exactly one cycle: max_valid is high in the cycle after the TLAST beat's edge, for one cycle only.
REQ-021 max_out and pkt_len SHALL hold their value until the next completed packet.
REQ-022 A new packet's first beat in the cycle immediately after TLAST SHALL be accepted with no bubble.
REQ-023 count SHALL saturate at 2^CNT_WIDTH-1; max tracking continues regardless.
REQ-024 Equal values SHALL NOT update run_max, so the first occurrence of the max wins.

Reset
REQ-025 Asserting ARESET_n=0 at any time, including mid-packet, SHALL immediately clear TREADY, max_out, max_valid, pkt_len, max_idx, run_max and count to 0, set FSM to IDLE, and discard any partial packet.

Configuration
REQ-026 With macro MAX_TEST3_INDEX_EN defined, output max_idx (CNT_WIDTH bits) SHALL exist, giving the zero-based beat index of the first occurrence of the max, updated with max_out.
REQ-027 Without MAX_TEST3_INDEX_EN, the port and its logic SHALL be absent and all other behaviour identical.

Structure
REQ-028 Package max_test3_pkg SHALL hold the FSM state enum (IDLE, ACCUM) and default STREAM_WIDTH/CNT_WIDTH constants.
REQ-029 A sub-module max_test3_cmp SHALL implement the unsigned strict-greater compare-and-select (inputs cur, cand; outputs sel_val, take).

Verification
REQ-030 Reset check: ARESET_n low 20 ns -> TREADY=0 and all outputs 0; TREADY=1 one edge after release.
REQ-031 Packet 5, 900, 3, 65000(TLAST) -> next cycle max_valid=1, max_out=65000, pkt_len=4 (max_idx=3).
REQ-032 Single beat 42 with TLAST -> max_out=42, pkt_len=1, max_idx=0.
REQ-033 Ties 7, 9, 9, 1(TLAST) -> max_out=9, pkt_len=4, max_idx=1.
REQ-034 TVALID gapped mid-packet (10, gap, 20(TLAST)), then back-to-back packet 3(TLAST) -> results 20/len 2, then 3/len 1 on consecutive pulses.
REQ-035 Reset asserted after beats 100, 200 -> outputs 0, TREADY=0; after release a new packet 50(TLAST) -> max_out=50, pkt_len=1.
